rob_commit_ctrl: RTL and testbench

In-order commit controller (reorder buffer) for the out-of-order core. Sits between rename (IDU) and the physical register file / free list.
- Allocates one entry per renamed instruction.
- Collects out-of-order completions from two execution result ports.
- Retires at most one instruction per cycle in program order. Retirement drives the IDU commit inputs (commit_valid, commit_with_write, commited_wr_register) and the PHY_REGFILE_WRAPPER commit write port.
- On a mispredicted branch reaching head, issues a one-cycle flush with redirect PC.

---
 rtl/rob_pkg.sv | 42 ++++
 rtl/rob_ptr.sv | 31 +++
 rtl/rob_commit_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and widths for the reorder-buffer commit controller.
// Widths use the core default values.
package rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int TAG_W      = $clog2(ROB_DEPTH);
  localparam int PTR_W      = TAG_W + 1;
  localparam int ARCH_REG_W = 5;
  localparam int NUM_CMPL   = 2;
  localparam int PHY_REG_W  = 6;
  localparam int VAL_W      = 32;
  localparam int ADDR_W     = 32;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  wr_en;
    logic [ARCH_REG_W-1:0] arch_rd;
    logic [PHY_REG_W-1:0]  phy_rd;
    logic [ADDR_W-1:0]     pc;
    logic [VAL_W-1:0]      val;
    logic                  mispredict;
    logic [ADDR_W-1:0]     target;
  } rob_entry_t;

  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic [VAL_W-1:0]  val;
    logic              mispredict;
    logic [ADDR_W-1:0] target;
  } cmpl_port_t;

  // Same index, opposite phase: the tail has lapped the head exactly once.
  function automatic logic ptr_full(input ptr_t head, input ptr_t tail);
    return (head[TAG_W-1:0] == tail[TAG_W-1:0]) && (head[TAG_W] != tail[TAG_W]);
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Phase-tagged circular pointer: index plus one wrap bit, with increment and load.
// Load takes priority so a flush can reposition the tail regardless of allocation.
module rob_ptr
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [PTR_W-1:0] load_val_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // NOTE: always_comb assigns a default first so no path leaves ptr_d unassigned (no latch).
  always_comb begin
    ptr_d = ptr_q;
    if (load_i)     ptr_d = load_val_i;
    else if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order commit controller: allocates at tail, completes out of order from two
// result ports, retires one done entry per cycle at head, flushes on a mispredicted head.
module rob_commit_ctrl
  import rob_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_valid,
  input  logic                       alloc_wr_en,
  input  logic [ARCH_REG_W-1:0]      alloc_arch_rd,
  input  logic [PHY_REG_W-1:0]       alloc_phy_rd,
  input  logic [ADDR_W-1:0]          alloc_pc,
  output logic                       alloc_ready,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [NUM_CMPL-1:0]        cmpl_valid,
  input  logic [NUM_CMPL*TAG_W-1:0]  cmpl_tag,
  input  logic [NUM_CMPL*VAL_W-1:0]  cmpl_val,
  input  logic [NUM_CMPL-1:0]        cmpl_mispredict,
  input  logic [NUM_CMPL*ADDR_W-1:0] cmpl_target,
  output logic                       commit_valid,
  output logic                       commit_with_write,
  output logic [PHY_REG_W-1:0]       commited_wr_register,
  output logic [ARCH_REG_W-1:0]      commit_arch_reg,
  output logic [VAL_W-1:0]           commit_wr_val,
  output logic [ADDR_W-1:0]          commit_pc,
  output logic                       flush_valid,
  output logic [ADDR_W-1:0]          flush_pc,
  output logic [TAG_W:0]             rob_count
);

  rob_entry_t rob_q [ROB_DEPTH];
  rob_entry_t rob_d [ROB_DEPTH];
  cmpl_port_t cmpl  [NUM_CMPL];

  logic [PTR_W-1:0] head_ptr, tail_ptr;
  tag_t             head_idx, tail_idx;
  rob_entry_t       head_e;
  logic             full, commit_fire, flush_pending, alloc_fire;
  logic [PTR_W-1:0] count_q, count_d;

  assign head_idx      = head_ptr[TAG_W-1:0];
  assign tail_idx      = tail_ptr[TAG_W-1:0];
  assign head_e        = rob_q[head_idx];
  assign full          = ptr_full(head_ptr, tail_ptr);
  assign commit_fire   = head_e.valid && head_e.done;
  assign flush_pending = commit_fire && head_e.mispredict;
  assign alloc_ready   = !full && !flush_pending;
  assign alloc_fire    = alloc_valid && alloc_ready;
  assign alloc_tag     = tail_idx;

  always_comb begin
    for (int p = 0; p < NUM_CMPL; p++) begin
      cmpl[p].valid      = cmpl_valid[p];
      cmpl[p].tag        = cmpl_tag[p*TAG_W +: TAG_W];
      cmpl[p].val        = cmpl_val[p*VAL_W +: VAL_W];
      cmpl[p].mispredict = cmpl_mispredict[p];
      cmpl[p].target     = cmpl_target[p*ADDR_W +: ADDR_W];
    end
  end

  rob_ptr u_head_ptr (
    .clk        (clk),
    .rst_n      (reset),
    .inc_i      (commit_fire),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (head_ptr)
  );

  // On flush the tail snaps to the post-commit head, leaving the buffer empty.
  rob_ptr u_tail_ptr (
    .clk        (clk),
    .rst_n      (reset),
    .inc_i      (alloc_fire),
    .load_i     (flush_pending),
    .load_val_i (head_ptr + 1'b1),
    .ptr_o      (tail_ptr)
  );

  always_comb begin
    rob_d = rob_q;
    if (flush_pending) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_d[i] = '0;
    end else begin
      // Port 1 is applied first so port 0 overwrites it on a shared tag.
      for (int p = NUM_CMPL-1; p >= 0; p--) begin
        if (cmpl[p].valid && rob_q[cmpl[p].tag].valid) begin
          rob_d[cmpl[p].tag].done       = 1'b1;
          rob_d[cmpl[p].tag].val        = cmpl[p].val;
          rob_d[cmpl[p].tag].mispredict = cmpl[p].mispredict;
          rob_d[cmpl[p].tag].target     = cmpl[p].target;
        end
      end
      if (commit_fire) rob_d[head_idx] = '0;
      if (alloc_fire) begin
        rob_d[tail_idx] = '{valid: 1'b1, done: 1'b0, wr_en: alloc_wr_en,
                            arch_rd: alloc_arch_rd, phy_rd: alloc_phy_rd,
                            pc: alloc_pc, val: '0, mispredict: 1'b0, target: '0};
      end
    end
  end

  // NOTE: the entry array is reset so valid/done bits are known-clear immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
    end else begin
      rob_q <= rob_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_pending) count_d = '0;
    else               count_d = count_q + PTR_W'(alloc_fire) - PTR_W'(commit_fire);
  end

  logic                  commit_valid_q, commit_with_write_q, flush_valid_q;
  logic [PHY_REG_W-1:0]  commit_phy_q;
  logic [ARCH_REG_W-1:0] commit_arch_q;
  logic [VAL_W-1:0]      commit_val_q;
  logic [ADDR_W-1:0]     commit_pc_q, flush_pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q             <= '0;
      commit_valid_q      <= 1'b0;
      commit_with_write_q <= 1'b0;
      commit_phy_q        <= '0;
      commit_arch_q       <= '0;
      commit_val_q        <= '0;
      commit_pc_q         <= '0;
      flush_valid_q       <= 1'b0;
      flush_pc_q          <= '0;
    end else begin
      count_q             <= count_d;
      commit_valid_q      <= commit_fire;
      commit_with_write_q <= commit_fire && head_e.wr_en;
      flush_valid_q       <= flush_pending;
      if (commit_fire) begin
        commit_phy_q  <= head_e.phy_rd;
        commit_arch_q <= head_e.arch_rd;
        commit_val_q  <= head_e.val;
        commit_pc_q   <= head_e.pc;
      end
      if (flush_pending) flush_pc_q <= head_e.target;
    end
  end

  assign commit_valid         = commit_valid_q;
  assign commit_with_write    = commit_with_write_q;
  assign commited_wr_register = commit_phy_q;
  assign commit_arch_reg      = commit_arch_q;
  assign commit_wr_val        = commit_val_q;
  assign commit_pc            = commit_pc_q;
  assign flush_valid          = flush_valid_q;
  assign flush_pc             = flush_pc_q;
  assign rob_count            = count_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed self-checking bench for rob_commit_ctrl: ordering, port priority,
// mispredict flush, pointer wrap and asynchronous reset.
module tb_rob_commit_ctrl;
  import rob_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       alloc_valid = 1'b0;
  logic                       alloc_wr_en = 1'b0;
  logic [ARCH_REG_W-1:0]      alloc_arch_rd = '0;
  logic [PHY_REG_W-1:0]       alloc_phy_rd = '0;
  logic [ADDR_W-1:0]          alloc_pc = '0;
  logic                       alloc_ready;
  logic [TAG_W-1:0]           alloc_tag;
  logic [NUM_CMPL-1:0]        cmpl_valid = '0;
  logic [NUM_CMPL*TAG_W-1:0]  cmpl_tag = '0;
  logic [NUM_CMPL*VAL_W-1:0]  cmpl_val = '0;
  logic [NUM_CMPL-1:0]        cmpl_mispredict = '0;
  logic [NUM_CMPL*ADDR_W-1:0] cmpl_target = '0;
  logic                       commit_valid;
  logic                       commit_with_write;
  logic [PHY_REG_W-1:0]       commited_wr_register;
  logic [ARCH_REG_W-1:0]      commit_arch_reg;
  logic [VAL_W-1:0]           commit_wr_val;
  logic [ADDR_W-1:0]          commit_pc;
  logic                       flush_valid;
  logic [ADDR_W-1:0]          flush_pc;
  logic [TAG_W:0]             rob_count;

  int n_tests = 0;
  int n_fail  = 0;

  rob_commit_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_valid          (alloc_valid),
    .alloc_wr_en          (alloc_wr_en),
    .alloc_arch_rd        (alloc_arch_rd),
    .alloc_phy_rd         (alloc_phy_rd),
    .alloc_pc             (alloc_pc),
    .alloc_ready          (alloc_ready),
    .alloc_tag            (alloc_tag),
    .cmpl_valid           (cmpl_valid),
    .cmpl_tag             (cmpl_tag),
    .cmpl_val             (cmpl_val),
    .cmpl_mispredict      (cmpl_mispredict),
    .cmpl_target          (cmpl_target),
    .commit_valid         (commit_valid),
    .commit_with_write    (commit_with_write),
    .commited_wr_register (commited_wr_register),
    .commit_arch_reg      (commit_arch_reg),
    .commit_wr_val        (commit_wr_val),
    .commit_pc            (commit_pc),
    .flush_valid          (flush_valid),
    .flush_pc             (flush_pc),
    .rob_count            (rob_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    cmpl_valid  = '0;
  endtask

  task automatic set_alloc(input logic wr, input logic [ADDR_W-1:0] pc,
                           input logic [PHY_REG_W-1:0] phy, input logic [ARCH_REG_W-1:0] arch);
    alloc_valid   = 1'b1;
    alloc_wr_en   = wr;
    alloc_pc      = pc;
    alloc_phy_rd  = phy;
    alloc_arch_rd = arch;
  endtask

  task automatic set_cmpl(input int p, input logic [TAG_W-1:0] tag, input logic [VAL_W-1:0] val,
                          input logic mp, input logic [ADDR_W-1:0] tgt);
    cmpl_valid[p]                  = 1'b1;
    cmpl_tag[p*TAG_W +: TAG_W]     = tag;
    cmpl_val[p*VAL_W +: VAL_W]     = val;
    cmpl_mispredict[p]             = mp;
    cmpl_target[p*ADDR_W +: ADDR_W] = tgt;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- 1: reset state, fill to full, dropped 17th alloc
    apply_reset();
    check("rst_commit_valid", commit_valid, 0);
    check("rst_flush_valid", flush_valid, 0);
    check("rst_rob_count", rob_count, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_tag", alloc_tag, 0);
    check("rst_commit_pc", commit_pc, 0);
    for (int i = 0; i < ROB_DEPTH; i++) begin
      check($sformatf("fill_tag_%0d", i), alloc_tag, i);
      set_alloc(1'b1, ADDR_W'(i * 4), PHY_REG_W'(i), ARCH_REG_W'(i));
      tick();
    end
    check("full_count", rob_count, 16);
    check("full_ready", alloc_ready, 0);
    set_alloc(1'b1, 32'hDEAD, 1, 1);
    tick();
    check("drop_tag", alloc_tag, 0);
    check("drop_count", rob_count, 16);
    check("drop_no_commit", commit_valid, 0);

    // ---- 2: out-of-order completion, in-order commit
    apply_reset();
    set_alloc(1'b1, 32'h100, 10, 1); tick();
    set_alloc(1'b1, 32'h104, 11, 2); tick();
    set_alloc(1'b1, 32'h108, 12, 3); tick();
    set_cmpl(0, 2, 32'h22, 1'b0, '0); tick();
    check("ooo_no_commit_a", commit_valid, 0);
    set_cmpl(0, 0, 32'h20, 1'b0, '0); tick();
    check("ooo_no_commit_b", commit_valid, 0);
    set_cmpl(0, 1, 32'h21, 1'b0, '0); tick();
    check("ooo_c0_valid", commit_valid, 1);
    check("ooo_c0_pc", commit_pc, 32'h100);
    check("ooo_c0_val", commit_wr_val, 32'h20);
    check("ooo_c0_phy", commited_wr_register, 10);
    check("ooo_c0_arch", commit_arch_reg, 1);
    tick();
    check("ooo_c1_valid", commit_valid, 1);
    check("ooo_c1_pc", commit_pc, 32'h104);
    check("ooo_c1_val", commit_wr_val, 32'h21);
    tick();
    check("ooo_c2_valid", commit_valid, 1);
    check("ooo_c2_pc", commit_pc, 32'h108);
    check("ooo_c2_val", commit_wr_val, 32'h22);
    check("ooo_c2_phy", commited_wr_register, 12);
    check("ooo_c2_wr", commit_with_write, 1);
    tick();
    check("ooo_idle_valid", commit_valid, 0);
    check("ooo_idle_pc_hold", commit_pc, 32'h108);
    check("ooo_idle_count", rob_count, 0);

    // ---- 3: both ports hit the same tag, port 0 wins
    check("dual_tag", alloc_tag, 3);
    set_alloc(1'b0, 32'h10C, 13, 4); tick();
    set_cmpl(0, 3, 32'hAA, 1'b0, '0);
    set_cmpl(1, 3, 32'hBB, 1'b0, '0);
    tick();
    check("dual_wait", commit_valid, 0);
    tick();
    check("dual_valid", commit_valid, 1);
    check("dual_val", commit_wr_val, 32'hAA);
    check("dual_nowr", commit_with_write, 0);
    check("dual_pc", commit_pc, 32'h10C);

    // ---- 4: mispredicted branch at head flushes younger entries
    apply_reset();
    set_alloc(1'b1, 32'h300, 20, 5); tick();
    set_alloc(1'b0, 32'h304, 21, 0); tick();
    set_alloc(1'b1, 32'h308, 22, 6); tick();
    set_alloc(1'b1, 32'h30C, 23, 7); tick();
    set_alloc(1'b1, 32'h310, 24, 8); tick();
    check("mp_count5", rob_count, 5);
    set_cmpl(0, 1, 32'h0, 1'b1, 32'h200);
    set_cmpl(1, 0, 32'h55, 1'b0, '0);
    tick();
    check("mp_wait", commit_valid, 0);
    set_cmpl(0, 2, 32'h66, 1'b0, '0);
    set_cmpl(1, 3, 32'h77, 1'b0, '0);
    tick();
    check("mp_c0_valid", commit_valid, 1);
    check("mp_c0_pc", commit_pc, 32'h300);
    check("mp_c0_val", commit_wr_val, 32'h55);
    check("mp_c0_noflush", flush_valid, 0);
    check("mp_pending_ready", alloc_ready, 0);
    set_cmpl(0, 4, 32'h88, 1'b0, '0);
    set_alloc(1'b1, 32'h400, 30, 9);
    tick();
    check("mp_br_valid", commit_valid, 1);
    check("mp_br_pc", commit_pc, 32'h304);
    check("mp_br_nowr", commit_with_write, 0);
    check("mp_flush", flush_valid, 1);
    check("mp_flush_pc", flush_pc, 32'h200);
    check("mp_count0", rob_count, 0);
    check("mp_ready", alloc_ready, 1);
    check("mp_tail", alloc_tag, 2);
    tick();
    check("mp_flush_pulse", flush_valid, 0);
    check("mp_after_valid", commit_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mp_quiet_%0d", i), commit_valid, 0);
    end
    set_alloc(1'b1, 32'h500, 31, 10); tick();
    set_cmpl(0, 2, 32'h99, 1'b0, '0); tick();
    tick();
    check("mp_resume_valid", commit_valid, 1);
    check("mp_resume_pc", commit_pc, 32'h500);

    // ---- 5: pointer wrap with one instruction in flight
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      check($sformatf("wrap_tag_%0d", i), alloc_tag, i % ROB_DEPTH);
      set_alloc(1'b1, ADDR_W'(32'h1000 + i), PHY_REG_W'(i), ARCH_REG_W'(i));
      tick();
      check($sformatf("wrap_cnt1_%0d", i), rob_count, 1);
      set_cmpl(0, TAG_W'(i % ROB_DEPTH), VAL_W'(i), 1'b0, '0);
      tick();
      tick();
      check($sformatf("wrap_cv_%0d", i), commit_valid, 1);
      check($sformatf("wrap_pc_%0d", i), commit_pc, 32'h1000 + i);
      check($sformatf("wrap_cnt0_%0d", i), rob_count, 0);
    end

    // ---- 6: asynchronous reset mid-cycle
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      set_alloc(1'b1, ADDR_W'(32'h600 + 4 * i), PHY_REG_W'(i + 1), ARCH_REG_W'(i + 1));
      tick();
    end
    set_cmpl(0, 0, 32'h1234, 1'b0, '0); tick();
    tick();
    check("ar_pre_valid", commit_valid, 1);
    check("ar_pre_count", rob_count, 6);
    #3;
    reset = 1'b0;
    #1;
    check("ar_valid", commit_valid, 0);
    check("ar_wr", commit_with_write, 0);
    check("ar_pc", commit_pc, 0);
    check("ar_val", commit_wr_val, 0);
    check("ar_count", rob_count, 0);
    check("ar_ready", alloc_ready, 1);
    check("ar_tag", alloc_tag, 0);
    check("ar_flush", flush_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ar_post_tag", alloc_tag, 0);
    set_alloc(1'b1, 32'h700, 5, 5); tick();
    check("ar_post_tag1", alloc_tag, 1);
    check("ar_post_count", rob_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
